// File: rtl/muldiv_sequencer.sv
// Iterative 32x32 multiply / restoring divide unit driving architectural HI/LO.
// Optional macro MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic        mf_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div_zero_q, div_zero_d;

  // Operand preparation for a new request
  logic        op_is_div;
  logic        op_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign op_is_div = op[1];
  assign op_signed = ~op[0];
  assign a_neg     = op_signed & src_a[31];
  assign b_neg     = op_signed & src_b[31];
  assign a_mag     = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag     = b_neg ? (~src_b + 32'd1) : src_b;

  // One multiply step: acc += mcand when the current multiplier bit is set
  logic [63:0] mul_acc_step;
  logic [63:0] mul_mcand_step;
  logic [31:0] mul_mplier_step;

  assign mul_acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_mcand_step  = {mcand_q[62:0], 1'b0};
  assign mul_mplier_step = {1'b0, mplier_q[31:1]};

  // One restoring divide step: remainder in acc_q[31:0], dividend/quotient in mplier_q
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_borrow;
  logic [31:0] div_rem_step;
  logic [31:0] div_quo_step;

  assign div_shift    = {acc_q[31:0], mplier_q[31]};
  assign div_diff     = div_shift - {1'b0, mcand_q[31:0]};
  assign div_borrow   = div_diff[32];
  assign div_rem_step = div_borrow ? div_shift[31:0] : div_diff[31:0];
  assign div_quo_step = {mplier_q[30:0], ~div_borrow};

  logic mul_last;
  logic last_step;

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = (cnt_q == 6'd31) || (mul_mplier_step == 32'd0);
`else
  assign mul_last = (cnt_q == 6'd31);
`endif

  assign last_step = is_div_q ? (cnt_q == 6'd31) : mul_last;

  // Sign correction applied on the final step's values so HI/LO load on the DONE-entry edge
  logic        res_neg;
  logic [63:0] mul_res;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  assign res_neg = neg_a_q ^ neg_b_q;
  assign mul_res = res_neg ? (~mul_acc_step + 64'd1) : mul_acc_step;
  assign quo_res = res_neg ? (~div_quo_step + 32'd1) : div_quo_step;
  assign rem_res = neg_a_q ? (~div_rem_step + 32'd1) : div_rem_step;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = op_is_div;
          neg_a_d  = a_neg;
          neg_b_d  = b_neg;
          cnt_d    = 6'd0;
          acc_d    = 64'd0;
          mcand_d  = {32'd0, (op_is_div ? b_mag : a_mag)};
          mplier_d = op_is_div ? a_mag : b_mag;
          if (op_is_div && (src_b == 32'd0)) begin
            hi_d       = src_a;
            lo_d       = 32'hFFFF_FFFF;
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            if (op_is_div) begin
              div_zero_d = 1'b0;
            end
            state_d = CALC;
          end
        end else begin
          if (mt_hi) begin
            hi_d = src_a;
          end
          if (mt_lo) begin
            lo_d = src_a;
          end
        end
      end

      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (is_div_q) begin
          acc_d    = {32'd0, div_rem_step};
          mplier_d = div_quo_step;
        end else begin
          acc_d    = mul_acc_step;
          mcand_d  = mul_mcand_step;
          mplier_d = mul_mplier_step;
        end
        if (last_step) begin
          state_d = DONE;
          if (is_div_q) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            hi_d = mul_res[63:32];
            lo_d = mul_res[31:0];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      is_div_q   <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      acc_q      <= 64'd0;
      mcand_q    <= 64'd0;
      mplier_q   <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign stall    = busy & (start | mf_req | mt_hi | mt_lo);

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  EX-stage mult/div issue request.
REQ-004 SHALL have ports: op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports: src_a  in  32  rs operand (multiplicand/dividend; MTHI/MTLO data).
REQ-006 SHALL have ports: src_b  in  32  rt operand (multiplier/divisor).
REQ-007 SHALL have ports: mt_hi, mt_lo  in  1 each  MTHI/MTLO write strobes.
REQ-008 SHALL have ports: mf_req  in  1  ID stage holds MFHI/MFLO.
REQ-009 SHALL have ports: hi, lo  out  32 each  architectural HI/LO registers.
REQ-010 SHALL have ports: busy  out  1  state != IDLE.
REQ-011 SHALL have ports: stall  out  1  combinational freeze request to hazard logic (pc_ld/IF_ID_write low, bubble).
REQ-012 SHALL have ports: done  out  1  one-cycle result-valid pulse.
REQ-013 SHALL have ports: div_zero  out  1  sticky flag, last divide had src_b == 0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; one clock domain clk.
REQ-015 SHALL, in IDLE with start=1, latch op/operands (magnitudes for signed ops, sign bits kept), clear counter, enter CALC next edge.
REQ-016 SHALL perform one shift-add (mult) or restoring shift-subtract (div) step per CALC cycle, 32 steps, counter 6 bits.
REQ-017 SHALL leave CALC after the 32nd step, apply sign correction in the same edge, load hi/lo, and enter DONE; start-to-DONE = 33 edges.
REQ-018 SHALL hold done=1 only in DONE; DONE -> IDLE unconditionally next edge.
REQ-019 SHALL produce: MULT/MULTU {hi,lo}=64-bit product, negated if operand signs differ (MULT).
REQ-020 SHALL produce: DIV/DIVU lo=quotient, hi=remainder; signed quotient negated if signs differ, remainder takes dividend sign.
REQ-021 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give lo=0x80000000, hi=0 (no trap).
REQ-022 SHALL, for divide with src_b==0, skip CALC: IDLE -> DONE next edge, hi=src_a, lo=0xFFFFFFFF, div_zero=1.
REQ-023 SHALL clear div_zero on any accepted divide with src_b != 0; multiplies leave it unchanged.
REQ-024 SHALL drive stall = busy & (start | mf_req | mt_hi | mt_lo); stall SHALL be 0 in IDLE.
REQ-025 SHALL ignore start, mt_hi, mt_lo while busy; the pipeline re-presents them after stall drops.
REQ-026 SHALL, in IDLE, write hi<=src_a on mt_hi, lo<=src_a on mt_lo; if start and mt_* coincide, start wins and mt_* is dropped.
REQ-027 SHALL keep hi/lo unchanged from start acceptance until DONE entry.

Reset
REQ-028 SHALL, when rst=0 at a clk edge, force IDLE, hi=0, lo=0, done=0, div_zero=0, counter=0, aborting any operation in progress.
REQ-029 SHALL ignore start/mt_* in the cycle rst=0; busy and stall SHALL be 0 the cycle after reset.

Configuration
REQ-030 SHALL honour macro MULDIV_EARLY_OUT_EN.
REQ-031 SHALL, with MULDIV_EARLY_OUT_EN defined, end multiply CALC once the remaining multiplier bits are all zero (minimum 1 CALC cycle; src_b=0 gives DONE 2 edges after start); divide timing unchanged.
REQ-032 SHALL, without the macro, use fixed 33-edge latency for all multiply and non-zero divide operations.

Verification
REQ-033 SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done 33 edges after start.
REQ-034 SHALL cover: MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 SHALL cover: DIVU 100/0 -> DONE next edge, hi=100, lo=0xFFFFFFFF, div_zero=1; a following DIVU 9/4 -> lo=2, hi=1, div_zero=0.
REQ-036 SHALL cover: mf_req held during CALC -> stall=1 every busy cycle, 0 in the cycle after DONE; mt_lo during CALC -> lo unchanged.
REQ-037 SHALL cover: rst=0 at CALC step 10 -> next cycle busy=0, hi=lo=0, no done pulse.
REQ-038 SHALL cover: with MULDIV_EARLY_OUT_EN, MULTU 5*3 -> lo=15, done 3 edges after start; without, 33.
